// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide share one hi/lo register pair.
// Divide-by-zero and signed overflow skip iteration and go straight to DONE.
// Optional macro FAST_MUL_EN: multiplies finish combinationally at accept (IDLE->DONE).
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [REG_AW-1:0] rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] rd_out,
  output logic              wb_en
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0]   hi, lo, b_mag;
  logic              neg, sel_lo, sel_rem;
  logic [CW-1:0]     cnt;
  logic [REG_AW-1:0] rd_lat;

  // Picks the requested product half after applying the sign fix-up.
  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                               input logic n, input logic lo_half);
    logic [2*XLEN-1:0] s;
    s = n ? -p : p;
    return lo_half ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  // Picks quotient or remainder after applying the sign fix-up.
  function automatic logic [XLEN-1:0] div_pick(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                               input logic n, input logic rem);
    logic [XLEN-1:0] s;
    s = rem ? r : q;
    return n ? -s : s;
  endfunction

  // Operand decode: signedness, magnitudes, result sign and special cases.
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;
  always_comb begin
    is_div      = funct3[2];
    a_sgn       = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn       = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg       = a_sgn & op_a[XLEN-1];
    b_neg       = b_sgn & op_b[XLEN-1];
    a_mag_in    = a_neg ? -op_a : op_a;
    b_mag_in    = b_neg ? -op_b : op_b;
    // remainder takes the dividend's sign; everything else takes the xor
    neg_in      = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = is_div && (op_b == '0);
    div_ovf     = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special     = div_zero | div_ovf;
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : op_a;
  end

`ifdef FAST_MUL_EN
  // Full-width product of the magnitudes, formed at accept.
  logic [2*XLEN-1:0] fast_prod;
  always_comb fast_prod = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
`endif

  // One iteration of each algorithm, computed from the current registers.
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt, div_diff;
  logic            div_ge, last;
  always_comb begin
    mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    mul_hi_nxt = mul_sum[XLEN:1];
    mul_lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    div_shift  = {hi, lo[XLEN-1]};
    div_ge     = div_shift >= {1'b0, b_mag};
    div_diff   = div_shift[XLEN-1:0] - b_mag;
    div_hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_lo_nxt = {lo[XLEN-2:0], div_ge};
    last       = (cnt == CW'(XLEN-1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) begin
        if (special)     state_nxt = S_DONE;
        else if (is_div) state_nxt = S_DIV;
`ifdef FAST_MUL_EN
        else             state_nxt = S_DONE;
`else
        else             state_nxt = S_MUL;
`endif
      end
      S_MUL:  if (last) state_nxt = S_DONE;
      S_DIV:  if (last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    wb_en = done && (rd_out != '0);
  end

  // Datapath: accept, iterate, and register the final result on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; b_mag <= '0; neg <= 1'b0; sel_lo <= 1'b0; sel_rem <= 1'b0;
      cnt <= '0; rd_lat <= '0; result <= '0; rd_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          hi      <= '0;
          lo      <= a_mag_in;
          b_mag   <= b_mag_in;
          neg     <= neg_in;
          sel_lo  <= (funct3 == 3'b000);
          sel_rem <= funct3[1];
          rd_lat  <= rd_in;
          cnt     <= '0;
          if (special) begin
            result <= special_res;
            rd_out <= rd_in;
          end
`ifdef FAST_MUL_EN
          else if (!is_div) begin
            result <= mul_pick(fast_prod, neg_in, funct3 == 3'b000);
            rd_out <= rd_in;
          end
`endif
        end
        S_MUL: begin
          hi  <= mul_hi_nxt;
          lo  <= mul_lo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= mul_pick({mul_hi_nxt, mul_lo_nxt}, neg, sel_lo);
            rd_out <= rd_lat;
          end
        end
        S_DIV: begin
          hi  <= div_hi_nxt;
          lo  <= div_lo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= div_pick(div_lo_nxt, div_hi_nxt, neg, sel_rem);
            rd_out <= rd_lat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed table, randomized ops vs. arithmetic model,
// start-held-while-busy, rd=x0 and mid-operation reset sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int pass_cnt = 0;
  int total    = 0;

`ifdef FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // RV32M semantics written straight from the ISA definition.
  function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'b000: begin ps = longint'(sa) * longint'(sb); return ps[31:0]; end
      3'b001: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'b010: begin ps = longint'(sa) * longint'({32'h0, b}); return ps[63:32]; end
      3'b011: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'b100: if (b == 0) return 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
              else return sa / sb;
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 0) return a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
              else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return LAT_MUL;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LAT_DIV;
  endfunction

  // Issue one op; when hold is set, start stays high and operands churn until done.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input bit hold);
    int k;
    bit seen;
    logic [31:0] held;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (hold) begin
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
      end
      if (k == 1) check({name, " busy"}, {31'b0, busy}, 32'd1);
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    check({name, " latency"}, seen ? k : 999, lat);
    check({name, " result"}, result, exp);
    check({name, " rd_out"}, {27'b0, rd_out}, {27'b0, rd});
    check({name, " wb_en"}, {31'b0, wb_en}, {31'b0, rd != 0});
    held = result;
    @(negedge clk);
    check({name, " done drops"}, {31'b0, done}, 32'd0);
    check({name, " result held"}, result, held);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t vt[12];
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rr;
    bit          early;

    vt[0]  = '{3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         LAT_MUL};
    vt[1]  = '{3'b001, 32'hFFFF_FFFF,  32'd2,          5'd1,  32'hFFFF_FFFF,  LAT_MUL};
    vt[2]  = '{3'b011, 32'hFFFF_FFFF,  32'd2,          5'd2,  32'h0000_0001,  LAT_MUL};
    vt[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  LAT_DIV};
    vt[4]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  LAT_DIV};
    vt[5]  = '{3'b101, 32'h0000_1234,  32'd0,          5'd6,  32'hFFFF_FFFF,  1};
    vt[6]  = '{3'b111, 32'h0000_1234,  32'd0,          5'd7,  32'h0000_1234,  1};
    vt[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1};
    vt[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h0000_0000,  1};
    vt[9]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 32'hFFFF_FFFF,  LAT_MUL};
    vt[10] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  LAT_DIV};
    vt[11] = '{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd11, 32'h4000_0000,  LAT_MUL};

    // reset state
    #12;
    check("reset busy",   {31'b0, busy},  32'd0);
    check("reset done",   {31'b0, done},  32'd0);
    check("reset wb_en",  {31'b0, wb_en}, 32'd0);
    check("reset result", result,         32'd0);
    check("reset rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].lat, 1'b0);

    // randomized ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 9);
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      rr = 5'($urandom);
      run_op($sformatf("rnd%0d", i), rf, ra, rb, rr, ref_fn(rf, ra, rb), ref_lat(rf, ra, rb), 1'b0);
    end

    // start held high while busy with churning operands; then rd=x0
    run_op("hold", 3'b100, 32'd1000, 32'd7, 5'd12, 32'd142, LAT_DIV, 1'b1);
    run_op("rd0",  3'b000, 32'd3,    32'd5, 5'd0,  32'd15,  LAT_MUL, 1'b0);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd12345; op_b = 32'd3; rd_in = 5'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) early = 1'b1;
    end
    check("no done after abort", {31'b0, early}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
